// File: rtl/f_fetch_ctrl_pkg.sv
// Shared definitions for the F-stage fetch controller: IM geometry, reset PC,
// controller state encoding and the byte-address to IM word-index mapping.
package f_fetch_ctrl_pkg;

  localparam logic [31:0] PC_DEFAULT  = 32'h0000_3000;
  localparam int          IM_ROM_SIZE = 4096;
  localparam int          IM_ADDR_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Word index of a byte address relative to the IM base; callers check legality first.
  function automatic logic [IM_ADDR_W-1:0] pc_to_index(input logic [31:0] pc,
                                                       input logic [31:0] base);
    return IM_ADDR_W'((pc - base) >> 2);
  endfunction

endpackage

// File: rtl/f_fetch_hold.sv
// One-entry output register for the F/D boundary: tracks pc/valid of the last
// issued read, freezes the RAM word on the first stall cycle, squashes on redirect.
module f_fetch_hold (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        redirect,
  input  logic        stall,
  input  logic        issue,
  input  logic [31:0] issue_pc,
  input  logic [31:0] rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  logic        holding;
  logic [31:0] hold_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      valid      <= 1'b0;
      holding    <= 1'b0;
      hold_instr <= '0;
    end else if (clear || redirect) begin
      valid   <= 1'b0;
      holding <= 1'b0;
    end else if (stall) begin
      // The RAM output is undefined once en drops, so latch it exactly once.
      if (!holding) begin
        hold_instr <= rdata;
        holding    <= 1'b1;
      end
    end else begin
      valid   <= issue;
      pc      <= issue_pc;
      holding <= 1'b0;
    end
  end

  assign instr = !valid ? 32'h0 : (holding ? hold_instr : rdata);

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage controller: boots the IM from a word-serial loader, then runs the fetch
// PC against the 1-cycle-latency IM RAM with stall, redirect and address-fault handling.
module f_fetch_ctrl
  import f_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_DEFAULT,
  parameter int          IM_DEPTH = IM_ROM_SIZE,
  parameter int          ADDR_W   = IM_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [31:0]       i_ld_data,
  input  logic              i_ld_last,
  output logic              o_im_en,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  input  logic [31:0]       i_im_rdata,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instr,
  output logic              o_valid,
  output logic              o_booted,
  output logic              o_addr_err
);

  localparam logic [31:0]       IM_BYTES = 32'(IM_DEPTH) << 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IM_DEPTH - 1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] ld_ptr, ld_ptr_nxt;
  logic [31:0]       f_pc, f_pc_nxt;
  logic [31:0]       pc_off;
  logic              pc_legal;
  logic              issue;

  // Unsigned offset from the IM base; below-base addresses are rejected explicitly.
  assign pc_off   = f_pc - PC_RESET;
  assign pc_legal = (f_pc[1:0] == 2'b00) && (f_pc >= PC_RESET) && (pc_off < IM_BYTES);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      ld_ptr <= '0;
      f_pc   <= PC_RESET;
    end else begin
      state  <= state_nxt;
      ld_ptr <= ld_ptr_nxt;
      f_pc   <= f_pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_ptr_nxt = ld_ptr;
    f_pc_nxt   = f_pc;
    o_ld_ready = 1'b0;
    o_im_en    = 1'b0;
    o_im_we    = 1'b0;
    o_im_addr  = '0;
    o_im_wdata = '0;
    issue      = 1'b0;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          o_im_en    = 1'b1;
          o_im_we    = 1'b1;
          o_im_addr  = ld_ptr;
          o_im_wdata = i_ld_data;
          ld_ptr_nxt = ld_ptr + 1'b1;
          if (i_ld_last || (ld_ptr == LAST_IDX)) state_nxt = RUN;
        end
      end
      RUN: begin
        // Redirect cycle issues nothing; the target is read on the following cycle.
        if (i_redirect) begin
          f_pc_nxt = i_redirect_pc;
        end else if (!i_stall) begin
          if (pc_legal) begin
            issue     = 1'b1;
            o_im_en   = 1'b1;
            o_im_addr = ADDR_W'(pc_to_index(f_pc, PC_RESET));
            f_pc_nxt  = f_pc + 32'd4;
          end else begin
            state_nxt = FAULT;
          end
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_booted   = (state == RUN) || (state == FAULT);
  assign o_addr_err = (state == FAULT);

  f_fetch_hold u_hold (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (state != RUN),
    .redirect (i_redirect),
    .stall    (i_stall),
    .issue    (issue),
    .issue_pc (f_pc),
    .rdata    (i_im_rdata),
    .pc       (o_pc),
    .instr    (o_instr),
    .valid    (o_valid)
  );

endmodule
